// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register.
// Captures the EXE-stage instruction one cycle later. While the memory stage
// freezes, the held load/store stays bit-exact. A flush that arrives while
// frozen is remembered and turns the next capture into a bubble, so an
// already-issued memory access is never killed.
// Debug side: a saturating count of stalled memory-op cycles and a sticky
// timeout flag for a freeze that never releases.
module exe_mem_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              freeze,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] st_value_in,
    input  logic [REG_W-1:0]  dest_in,
    output logic              valid,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] st_value,
    output logic [REG_W-1:0]  dest,
    output logic [CNT_W-1:0]  stall_count,
    output logic              timeout
);

    // Consecutive-freeze counter only has to reach TIMEOUT; it saturates there.
    localparam int              FC_W    = $clog2(TIMEOUT + 1);
    localparam logic [FC_W-1:0] FC_MAX  = FC_W'(TIMEOUT);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(TIMEOUT - 1);

    typedef enum logic {
        ST_RUN,
        ST_HOLD
    } state_t;

    state_t            state_reg;
    logic              pending_flush_reg;
    logic [FC_W-1:0]   frz_cnt_reg;
    logic              timeout_reg;
    logic [CNT_W-1:0]  stall_count_reg;

    logic              valid_reg;
    logic              wb_en_reg;
    logic              mem_r_en_reg;
    logic              mem_w_en_reg;
    logic [DATA_W-1:0] alu_result_reg;
    logic [DATA_W-1:0] st_value_reg;
    logic [REG_W-1:0]  dest_reg;

    // Values loaded on a capture edge.
    logic              valid_next;
    logic              wb_en_next;
    logic              mem_r_en_next;
    logic              mem_w_en_next;
    logic [DATA_W-1:0] alu_result_next;
    logic [DATA_W-1:0] st_value_next;
    logic [REG_W-1:0]  dest_next;

    logic              mem_busy;

    // A held instruction counts as a stalled memory access only if it is a
    // real load or store.
    assign mem_busy = valid_reg & (mem_r_en_reg | mem_w_en_reg);

    // Capture values: a bubble (all zero) on a live or remembered flush,
    // otherwise the EXE instruction with its enables gated by valid_in.
    // Illegal read+write combinations pass through untouched.
    always_comb begin
        valid_next      = 1'b0;
        wb_en_next      = 1'b0;
        mem_r_en_next   = 1'b0;
        mem_w_en_next   = 1'b0;
        alu_result_next = '0;
        st_value_next   = '0;
        dest_next       = '0;
        if (!(flush || pending_flush_reg)) begin
            valid_next      = valid_in;
            wb_en_next      = wb_en_in & valid_in;
            mem_r_en_next   = mem_r_en_in & valid_in;
            mem_w_en_next   = mem_w_en_in & valid_in;
            alu_result_next = alu_result_in;
            st_value_next   = st_value_in;
            dest_next       = dest_in;
        end
    end

    // RUN/HOLD control: capture on every unfrozen edge, hold while frozen and
    // remember any flush seen during the hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= ST_RUN;
            pending_flush_reg <= 1'b0;
            valid_reg         <= 1'b0;
            wb_en_reg         <= 1'b0;
            mem_r_en_reg      <= 1'b0;
            mem_w_en_reg      <= 1'b0;
            alu_result_reg    <= '0;
            st_value_reg      <= '0;
            dest_reg          <= '0;
        end else begin
            if (freeze) begin
                if (state_reg == ST_RUN) begin
                    // Pending flag is always clear in RUN, so this is a plain load.
                    pending_flush_reg <= flush;
                end else if (flush) begin
                    pending_flush_reg <= 1'b1;
                end
                state_reg <= ST_HOLD;
            end else begin
                valid_reg         <= valid_next;
                wb_en_reg         <= wb_en_next;
                mem_r_en_reg      <= mem_r_en_next;
                mem_w_en_reg      <= mem_w_en_next;
                alu_result_reg    <= alu_result_next;
                st_value_reg      <= st_value_next;
                dest_reg          <= dest_next;
                pending_flush_reg <= 1'b0;
                state_reg         <= ST_RUN;
            end
        end
    end

    // Stall statistics: saturating stalled-access count, consecutive-freeze
    // counter, and the sticky timeout raised on the TIMEOUT-th frozen edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count_reg <= '0;
            frz_cnt_reg     <= '0;
            timeout_reg     <= 1'b0;
        end else begin
            if (freeze && mem_busy && !(&stall_count_reg)) begin
                stall_count_reg <= stall_count_reg + CNT_W'(1);
            end
            if (freeze) begin
                if (frz_cnt_reg != FC_MAX) begin
                    frz_cnt_reg <= frz_cnt_reg + FC_W'(1);
                end
                if (frz_cnt_reg >= FC_LAST) begin
                    timeout_reg <= 1'b1;
                end
            end else begin
                frz_cnt_reg <= '0;
            end
        end
    end

    assign valid       = valid_reg;
    assign wb_en       = wb_en_reg;
    assign mem_r_en    = mem_r_en_reg;
    assign mem_w_en    = mem_w_en_reg;
    assign alu_result  = alu_result_reg;
    assign st_value    = st_value_reg;
    assign dest        = dest_reg;
    assign stall_count = stall_count_reg;
    assign timeout     = timeout_reg;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Bench for exe_mem_pipe_reg: directed vectors, a behavioural reference model
// checked every cycle, and literal expectations at key points. A second
// instance with a 4-bit stall counter shares the stimulus.
module tb_exe_mem_pipe_reg;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 4;
    localparam int TIMEOUT = 1023;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              freeze, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [DATA_W-1:0] alu_result_in, st_value_in;
    logic [REG_W-1:0]  dest_in;

    logic              valid, wb_en, mem_r_en, mem_w_en, timeout;
    logic [DATA_W-1:0] alu_result, st_value;
    logic [REG_W-1:0]  dest;
    logic [15:0]       stall_count;

    logic              valid4, wb_en4, mem_r_en4, mem_w_en4, timeout4;
    logic [DATA_W-1:0] alu_result4, st_value4;
    logic [REG_W-1:0]  dest4;
    logic [3:0]        stall_count4;

    int n_total = 0;
    int n_pass  = 0;

    exe_mem_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .alu_result_in(alu_result_in),
        .st_value_in(st_value_in), .dest_in(dest_in),
        .valid(valid), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_result(alu_result), .st_value(st_value), .dest(dest),
        .stall_count(stall_count), .timeout(timeout)
    );

    exe_mem_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(4), .TIMEOUT(TIMEOUT)) dut4 (
        .clock(clock), .reset(reset), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .alu_result_in(alu_result_in),
        .st_value_in(st_value_in), .dest_in(dest_in),
        .valid(valid4), .wb_en(wb_en4), .mem_r_en(mem_r_en4), .mem_w_en(mem_w_en4),
        .alu_result(alu_result4), .st_value(st_value4), .dest(dest4),
        .stall_count(stall_count4), .timeout(timeout4)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: the instruction MEM should be holding, plus stall bookkeeping.
    logic              m_valid, m_wb, m_r, m_w, m_pend, m_to;
    logic [DATA_W-1:0] m_alu, m_st;
    logic [REG_W-1:0]  m_dest;
    int                m_frz, m_stall, m_stall4;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            {m_valid, m_wb, m_r, m_w, m_pend, m_to} <= '0;
            m_alu <= '0; m_st <= '0; m_dest <= '0;
            m_frz <= 0; m_stall <= 0; m_stall4 <= 0;
        end else if (freeze) begin
            if (flush) m_pend <= 1'b1;
            if (m_valid && (m_r || m_w)) begin
                m_stall  <= (m_stall  < 65535) ? m_stall  + 1 : m_stall;
                m_stall4 <= (m_stall4 < 15)    ? m_stall4 + 1 : m_stall4;
            end
            m_frz <= m_frz + 1;
            if (m_frz + 1 >= TIMEOUT) m_to <= 1'b1;
        end else begin
            m_frz  <= 0;
            m_pend <= 1'b0;
            if (flush || m_pend) begin
                {m_valid, m_wb, m_r, m_w} <= '0;
                m_alu <= '0; m_st <= '0; m_dest <= '0;
            end else begin
                m_valid <= valid_in;
                m_wb    <= valid_in && wb_en_in;
                m_r     <= valid_in && mem_r_en_in;
                m_w     <= valid_in && mem_w_en_in;
                m_alu   <= alu_result_in;
                m_st    <= st_value_in;
                m_dest  <= dest_in;
            end
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clock) begin
        check("ctrl",  64'({valid, wb_en, mem_r_en, mem_w_en, dest, timeout}),
                       64'({m_valid, m_wb, m_r, m_w, m_dest, m_to}));
        check("data",  {alu_result, st_value}, {m_alu, m_st});
        check("ctrl4", 64'({valid4, wb_en4, mem_r_en4, mem_w_en4, dest4, timeout4}),
                       64'({m_valid, m_wb, m_r, m_w, m_dest, m_to}));
        check("data4", {alu_result4, st_value4}, {m_alu, m_st});
        check("stall", 64'({stall_count, stall_count4}), 64'({m_stall[15:0], m_stall4[3:0]}));
    end

    task automatic drive(input logic v, input logic wb, input logic r, input logic w,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] s,
                         input logic [REG_W-1:0] d, input logic fz, input logic fl);
        valid_in = v; wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
        alu_result_in = a; st_value_in = s; dest_in = d; freeze = fz; flush = fl;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        drive(0, 0, 0, 0, '0, '0, '0, 0, 0);
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_outputs", 64'({valid, wb_en, mem_r_en, mem_w_en, dest, timeout, stall_count}), 64'd0);
        check("reset_data", {alu_result, st_value}, 64'd0);
        reset = 1'b0;

        $display("txn load 0x100");
        drive(1, 1, 1, 0, 32'h100, 32'h0, 4'd3, 0, 0);
        step();
        check("load_r_en", 64'(mem_r_en), 64'd1);
        check("load_addr", 64'(alu_result), 64'h100);
        check("load_valid", 64'(valid), 64'd1);

        $display("txn store 0xDEADBEEF -> 0x40");
        drive(1, 0, 0, 1, 32'h40, 32'hDEADBEEF, 4'd0, 0, 0);
        step();
        check("store_w_en", 64'(mem_w_en), 64'd1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 0, 32'h900 + i, 32'h12340000 + i, 4'(i + 5), 1, i == 2);
            step();
            check("hold_addr", 64'(alu_result), 64'h40);
            check("hold_data", 64'(st_value), 64'hDEADBEEF);
            check("hold_w_en", 64'(mem_w_en), 64'd1);
        end
        check("stall_5", 64'(stall_count), 64'd5);
        check("stall4_5", 64'(stall_count4), 64'd5);

        $display("txn unfreeze with pending flush, then load 0x200");
        drive(1, 1, 1, 0, 32'h200, 32'h0, 4'd9, 0, 0);
        step();
        check("pend_bubble_valid", 64'(valid), 64'd0);
        check("pend_bubble_w_en", 64'(mem_w_en), 64'd0);
        check("pend_bubble_addr", 64'(alu_result), 64'd0);
        step();
        check("after_bubble_addr", 64'(alu_result), 64'h200);
        check("after_bubble_valid", 64'({valid, mem_r_en}), 64'b11);

        $display("txn flush while running");
        drive(1, 1, 0, 1, 32'h80, 32'h5, 4'd2, 0, 1);
        step();
        check("run_flush", 64'({valid, wb_en, mem_w_en, dest}), 64'd0);

        $display("txn invalid store");
        drive(0, 1, 0, 1, 32'h55, 32'h66, 4'd7, 0, 0);
        step();
        check("inv_enables", 64'({valid, wb_en, mem_r_en, mem_w_en}), 64'd0);
        check("inv_data", 64'({alu_result, dest}), {28'd0, 32'h55, 4'd7});

        $display("txn illegal read+write");
        drive(1, 0, 1, 1, 32'h66, 32'h77, 4'd1, 0, 0);
        step();
        check("illegal_rw", 64'({valid, mem_r_en, mem_w_en}), 64'b111);

        $display("txn freeze with no valid memory op");
        drive(0, 0, 1, 0, 32'h77, 32'h0, 4'd0, 0, 0);
        step();
        drive(0, 0, 1, 0, 32'h78, 32'h0, 4'd0, 1, 0);
        repeat (3) step();
        check("noop_stall", 64'(stall_count), 64'd5);

        $display("txn store frozen 20 cycles");
        drive(1, 0, 0, 1, 32'h88, 32'h1234, 4'd0, 0, 0);
        step();
        drive(1, 0, 0, 1, 32'h88, 32'h1234, 4'd0, 1, 0);
        repeat (20) step();
        check("stall_25", 64'(stall_count), 64'd25);
        check("stall4_sat", 64'(stall_count4), 64'd15);
        check("no_timeout_20", 64'(timeout), 64'd0);
        drive(0, 0, 0, 0, '0, '0, '0, 0, 0);
        step();

        $display("txn timeout run");
        drive(1, 0, 0, 1, 32'hA0, 32'hB0, 4'd0, 0, 0);
        step();
        freeze = 1'b1;
        repeat (TIMEOUT - 1) step();
        check("timeout_1022", 64'(timeout), 64'd0);
        step();
        check("timeout_1023", 64'(timeout), 64'd1);
        check("stall_1048", 64'(stall_count), 64'd1048);
        freeze = 1'b0;
        repeat (2) step();
        check("timeout_sticky", 64'(timeout), 64'd1);

        $display("txn async reset mid-freeze");
        freeze = 1'b1;
        repeat (2) step();
        #2 reset = 1'b1;
        #1;
        check("midreset_ctrl", 64'({valid, wb_en, mem_r_en, mem_w_en, dest, timeout, stall_count}), 64'd0);
        check("midreset_data", {alu_result, st_value}, 64'd0);
        check("midreset_stall4", 64'({timeout4, stall_count4}), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        drive(1, 1, 1, 0, 32'h300, 32'h0, 4'd4, 0, 0);
        step();
        check("post_reset_load", 64'({valid, mem_r_en, alu_result}), {30'd0, 2'b11, 32'h300});
        drive(0, 0, 0, 0, '0, '0, '0, 0, 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
